// File: rtl/cdc_pulse_arb.sv
// Round-robin scheduler sharing one source-domain pulse-CDC channel among N requesters.
// Queues one event per requester, issues it, then waits for the acknowledge or a timeout.
module cdc_pulse_arb #(
  parameter int unsigned N       = 4,
  parameter int unsigned IDW     = 2,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned GAP     = 2
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [N-1:0]   req_i,
  output logic [N-1:0]   pend_o,
  output logic [N-1:0]   ovf_o,
  input  logic [N-1:0]   ovf_clr_i,
  output logic           ch_req_o,
  output logic [IDW-1:0] ch_id_o,
  input  logic           ch_done_i,
  output logic [N-1:0]   done_o,
  output logic           tmo_o,
  output logic [7:0]     tmo_cnt_o,
  output logic           busy_o
);

  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam int unsigned GW = $clog2(GAP + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StGap} state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   pend_q, pend_d, ovf_q, ovf_d, done_q, done_d, grant;
  logic [IDW-1:0] ch_id_q, ch_id_d, last_q, last_d, win_id;
  logic           win_valid, ch_req_q, ch_req_d, tmo_q, tmo_d, busy_q, busy_d;
  logic [7:0]     tmo_cnt_q, tmo_cnt_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [GW-1:0]  gap_q, gap_d;

  // Round-robin pick: first pending index above last_q, else the lowest pending index.
  always_comb begin
    win_valid = 1'b0;
    win_id    = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (!win_valid && pend_q[i] && (i > int'(last_q))) begin
        win_valid = 1'b1;
        win_id    = IDW'(i);
      end
    end
    for (int i = 0; i < int'(N); i++) begin
      if (!win_valid && pend_q[i]) begin
        win_valid = 1'b1;
        win_id    = IDW'(i);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < int'(N); i++) begin
      grant[i] = (state_q == StIdle) && win_valid && (win_id == IDW'(i));
    end
  end

  always_comb begin
    state_d   = state_q;
    ch_id_d   = ch_id_q;
    last_d    = last_q;
    timer_d   = timer_q;
    gap_d     = gap_q;
    tmo_cnt_d = tmo_cnt_q;
    ch_req_d  = 1'b0;
    done_d    = '0;
    tmo_d     = 1'b0;

    // A req coinciding with its own grant re-arms pend without counting as overflow.
    pend_d = req_i | (pend_q & ~grant);
    ovf_d  = (req_i & pend_q & ~grant) | (ovf_q & ~ovf_clr_i);

    unique case (state_q)
      StIdle: begin
        if (win_valid) begin
          state_d  = StIssue;
          ch_id_d  = win_id;
          last_d   = win_id;
          ch_req_d = 1'b1;
        end
      end
      StIssue: begin
        timer_d = '0;
        state_d = StWait;
      end
      StWait: begin
        if (ch_done_i) begin
          for (int i = 0; i < int'(N); i++) begin
            done_d[i] = (ch_id_q == IDW'(i));
          end
          gap_d   = '0;
          state_d = StGap;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          tmo_d     = 1'b1;
          tmo_cnt_d = (tmo_cnt_q == 8'hFF) ? tmo_cnt_q : tmo_cnt_q + 8'd1;
          gap_d     = '0;
          state_d   = StGap;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      StGap: begin
        if (gap_q == GW'(GAP - 1)) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      pend_q    <= '0;
      ovf_q     <= '0;
      done_q    <= '0;
      ch_id_q   <= '0;
      last_q    <= IDW'(N - 1);
      timer_q   <= '0;
      gap_q     <= '0;
      tmo_cnt_q <= '0;
      ch_req_q  <= 1'b0;
      tmo_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
      ch_id_q   <= ch_id_d;
      last_q    <= last_d;
      timer_q   <= timer_d;
      gap_q     <= gap_d;
      tmo_cnt_q <= tmo_cnt_d;
      ch_req_q  <= ch_req_d;
      tmo_q     <= tmo_d;
      busy_q    <= busy_d;
    end
  end

  assign pend_o    = pend_q;
  assign ovf_o     = ovf_q;
  assign ch_req_o  = ch_req_q;
  assign ch_id_o   = ch_id_q;
  assign done_o    = done_q;
  assign tmo_o     = tmo_q;
  assign tmo_cnt_o = tmo_cnt_q;
  assign busy_o    = busy_q;

endmodule
